// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl: two-SPRAM ping-pong frame store controller between camera capture and SPI transmitter
module pingpong_ctrl #(
  parameter int ADDR_WIDTH  = 14,
  parameter int FRAME_WORDS = 10240
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cam_sof,
  input  logic                  pix_valid,
  input  logic [15:0]           pix_data,
  output logic                  frame_ready,
  output logic                  buf_sel,
  input  logic                  frame_busy,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [15:0]           rd_data,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [ADDR_WIDTH-1:0] ram_addr1,
  output logic [15:0]           ram_wdata0,
  output logic [15:0]           ram_wdata1,
  output logic                  ram_we0,
  output logic                  ram_we1,
  input  logic [15:0]           ram_rdata0,
  input  logic [15:0]           ram_rdata1,
  output logic [7:0]            frames_dropped
);
  typedef enum logic [1:0] {FREE, FILLING, FULL, SENDING} buf_t;
  typedef enum logic [1:0] {W_WAIT_SOF, W_FILL, W_DROP} wr_t;
  typedef enum logic [1:0] {R_IDLE, R_OFFER, R_WAIT_BUSY, R_SEND} rd_t;
  buf_t                  bst [2];
  wr_t                   wst;
  rd_t                   rdst;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic                  fill_buf;
  logic                  last_filled;
  logic                  pick;
  logic                  oldest;
  logic                  last_word;
  logic                  fill_we;
  logic [1:0]            free_v;
  logic [1:0]            full_v;
  logic [7:0]            drop_inc;
  always_comb begin
    free_v    = {bst[1] == FREE, bst[0] == FREE};
    full_v    = {bst[1] == FULL, bst[0] == FULL};
    pick      = &free_v ? ~last_filled : free_v[1];
    oldest    = &full_v ? ~last_filled : full_v[1];
    fill_addr = cam_sof ? '0 : wr_addr;
    fill_we   = wst == W_FILL && pix_valid;
    last_word = wr_addr == ADDR_WIDTH'(FRAME_WORDS - 1);
    drop_inc  = &frames_dropped ? frames_dropped : frames_dropped + 8'd1;
    ram_addr0 = bst[0] == FILLING ? fill_addr : bst[0] == SENDING ? rd_addr : '0;
    ram_addr1 = bst[1] == FILLING ? fill_addr : bst[1] == SENDING ? rd_addr : '0;
    ram_we0   = bst[0] == FILLING && fill_we;
    ram_we1   = bst[1] == FILLING && fill_we;
  end
  assign ram_wdata0 = pix_data;
  assign ram_wdata1 = pix_data;
  assign rd_data    = buf_sel ? ram_rdata1 : ram_rdata0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bst[0]         <= FREE;
      bst[1]         <= FREE;
      wst            <= W_WAIT_SOF;
      rdst           <= R_IDLE;
      wr_addr        <= '0;
      fill_buf       <= 1'b0;
      last_filled    <= 1'b1;
      buf_sel        <= 1'b0;
      frame_ready    <= 1'b0;
      frames_dropped <= '0;
    end else begin
      case (wst)
        W_FILL: begin
          if (cam_sof) begin
            frames_dropped <= drop_inc;
            wr_addr        <= ADDR_WIDTH'(pix_valid);
          end else if (pix_valid) begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
            if (last_word) begin
              bst[fill_buf] <= FULL;
              wst           <= W_WAIT_SOF;
            end
          end
        end
        default: begin
          if (cam_sof && |free_v) begin
            bst[pick]   <= FILLING;
            fill_buf    <= pick;
            last_filled <= pick;
            wr_addr     <= '0;
            wst         <= W_FILL;
          end else if (cam_sof) begin
            frames_dropped <= drop_inc;
            wst            <= W_DROP;
          end
        end
      endcase
      case (rdst)
        R_IDLE: begin
          if (|full_v) begin
            buf_sel     <= oldest;
            frame_ready <= 1'b1;
            rdst        <= R_OFFER;
          end
        end
        R_OFFER: begin
          frame_ready  <= 1'b0;
          bst[buf_sel] <= SENDING;
          rdst         <= R_WAIT_BUSY;
        end
        R_WAIT_BUSY: rdst <= frame_busy ? R_SEND : R_WAIT_BUSY;
        default: begin
          if (!frame_busy) begin
            bst[buf_sel] <= FREE;
            rdst         <= R_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pingpong_ctrl.sv
// tb_pingpong_ctrl: directed self-checking bench for pingpong_ctrl with a 16-word frame
module tb_pingpong_ctrl;
  localparam int AW = 14;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          cam_sof;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic          frame_ready;
  logic          buf_sel;
  logic          frame_busy;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic [AW-1:0] ram_addr0;
  logic [AW-1:0] ram_addr1;
  logic [15:0]   ram_wdata0;
  logic [15:0]   ram_wdata1;
  logic          ram_we0;
  logic          ram_we1;
  logic [15:0]   ram_rdata0;
  logic [15:0]   ram_rdata1;
  logic [7:0]    frames_dropped;
  int            n_cmp = 0;
  int            n_err = 0;
  pingpong_ctrl #(.ADDR_WIDTH(AW), .FRAME_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .cam_sof(cam_sof), .pix_valid(pix_valid), .pix_data(pix_data),
    .frame_ready(frame_ready), .buf_sel(buf_sel), .frame_busy(frame_busy), .rd_addr(rd_addr),
    .rd_data(rd_data), .ram_addr0(ram_addr0), .ram_addr1(ram_addr1), .ram_wdata0(ram_wdata0),
    .ram_wdata1(ram_wdata1), .ram_we0(ram_we0), .ram_we1(ram_we1), .ram_rdata0(ram_rdata0),
    .ram_rdata1(ram_rdata1), .frames_dropped(frames_dropped)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic sof();
    cam_sof = 1'b1;
    cyc();
    cam_sof = 1'b0;
  endtask
  task automatic pix(input int n, input int a0, input logic [15:0] base, input logic [1:0] we_exp);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = base + 16'(i);
      #1;
      chk("we", 32'({ram_we1, ram_we0}), 32'(we_exp));
      if (we_exp[0]) chk("addr0", 32'(ram_addr0), 32'(a0 + i));
      if (we_exp[1]) chk("addr1", 32'(ram_addr1), 32'(a0 + i));
      if (we_exp[0]) chk("wdata0", 32'(ram_wdata0), 32'(pix_data));
      if (we_exp[1]) chk("wdata1", 32'(ram_wdata1), 32'(pix_data));
      cyc();
    end
    pix_valid = 1'b0;
  endtask
  task automatic offer(input logic exp_sel, input logic [15:0] exp_data);
    #1;
    chk("ready_early", 32'(frame_ready), 32'd0);
    cyc();
    #1;
    chk("ready", 32'(frame_ready), 32'd1);
    chk("buf_sel", 32'(buf_sel), 32'(exp_sel));
    chk("rd_data", 32'(rd_data), 32'(exp_data));
    cyc();
    #1;
    chk("ready_pulse", 32'(frame_ready), 32'd0);
  endtask
  initial begin
    rst_n = 1'b0; cam_sof = 1'b0; pix_valid = 1'b0; pix_data = '0; frame_busy = 1'b0;
    rd_addr = '0; ram_rdata0 = 16'hAAAA; ram_rdata1 = 16'h5555;
    cyc();
    cyc();
    #1;
    chk("rst_ready", 32'(frame_ready), 32'd0);
    chk("rst_sel", 32'(buf_sel), 32'd0);
    chk("rst_we", 32'({ram_we1, ram_we0}), 32'd0);
    chk("rst_addr", 32'({ram_addr1, ram_addr0}), 32'd0);
    chk("rst_drop", 32'(frames_dropped), 32'd0);
    rst_n = 1'b1;
    cyc();
    pix(2, 0, 16'h0, 2'b00);
    // frame 1 into buffer 0
    sof();
    pix(16, 0, 16'h0000, 2'b01);
    offer(1'b0, 16'hAAAA);
    rd_addr = 14'd5;
    #1;
    chk("rd_addr_mux", 32'(ram_addr0), 32'd5);
    frame_busy = 1'b1;
    cyc();
    // frame 2 into buffer 1 while buffer 0 is being sent
    sof();
    pix(16, 0, 16'h0100, 2'b10);
    cyc();
    cyc();
    #1;
    chk("no_offer_busy", 32'(frame_ready), 32'd0);
    // frame 3 has nowhere to go
    sof();
    #1;
    chk("drop1", 32'(frames_dropped), 32'd1);
    pix(4, 0, 16'h0200, 2'b00);
    frame_busy = 1'b0;
    cyc();
    offer(1'b1, 16'h5555);
    // truncated frame restarts buffer 0
    frame_busy = 1'b1;
    sof();
    pix(7, 0, 16'h0300, 2'b01);
    cam_sof = 1'b1; pix_valid = 1'b1; pix_data = 16'h0400;
    #1;
    chk("trunc_we", 32'({ram_we1, ram_we0}), 32'd1);
    chk("trunc_addr", 32'(ram_addr0), 32'd0);
    cyc();
    cam_sof = 1'b0;
    #1;
    chk("drop2", 32'(frames_dropped), 32'd2);
    pix(15, 1, 16'h0401, 2'b01);
    frame_busy = 1'b0;
    cyc();
    offer(1'b0, 16'hAAAA);
    // transmitter aborts after 100 busy cycles
    frame_busy = 1'b1;
    repeat (100) cyc();
    frame_busy = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("no_reoffer", 32'(frame_ready), 32'd0);
      cyc();
    end
    sof();
    pix(16, 0, 16'h0500, 2'b10);
    offer(1'b1, 16'h5555);
    frame_busy = 1'b1;
    cyc();
    // reset with buffer 1 sending and buffer 0 filling
    sof();
    pix(5, 0, 16'h0600, 2'b01);
    pix_valid = 1'b1;
    rst_n = 1'b0;
    cyc();
    #1;
    chk("mid_rst_we", 32'({ram_we1, ram_we0}), 32'd0);
    chk("mid_rst_addr", 32'({ram_addr1, ram_addr0}), 32'd0);
    chk("mid_rst_ready", 32'(frame_ready), 32'd0);
    chk("mid_rst_sel", 32'(buf_sel), 32'd0);
    chk("mid_rst_drop", 32'(frames_dropped), 32'd0);
    rst_n = 1'b1; pix_valid = 1'b0; frame_busy = 1'b0;
    cyc();
    sof();
    pix(16, 0, 16'h0700, 2'b01);
    offer(1'b0, 16'hAAAA);
    frame_busy = 1'b1;
    cyc();
    // transmitter stalled: buffer 1 fills, then every frame drops
    sof();
    pix(16, 0, 16'h0800, 2'b10);
    for (int i = 1; i <= 300; i++) begin
      sof();
      if (i == 1 || i == 254 || i == 255) chk("drop_count", 32'(frames_dropped), 32'(i));
      cyc();
    end
    chk("drop_sat", 32'(frames_dropped), 32'd255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pingpong_ctrl.md
# pingpong_ctrl

Controller for the two-SPRAM ping-pong frame store between camera capture and the SPI frame transmitter. Owns both SPRAM ports: it steers incoming pixel words into a free buffer, marks it full at end-of-frame, and offers full buffers to the transmitter through the frame_ready / buf_sel / frame_busy handshake. It then muxes the transmitter's read address onto the buffer being sent, and drops whole frames when no buffer is free.

## Interface
- ADDR_WIDTH, 14, word address width per buffer
- FRAME_WORDS, 10240, 16-bit words per frame (≤ 2^ADDR_WIDTH)
- clk  in  1  system clock (shared with capture and transmitter)
- rst_n  in  1  reset, synchronous, active-low
- cam_sof  in  1  1-cycle start-of-frame pulse from capture
- pix_valid  in  1  pix_data valid this cycle
- pix_data  in  16  pixel word
- frame_ready  out  1  1-cycle pulse: buffer buf_sel is full and offered
- buf_sel  out  1  buffer index offered / being sent
- frame_busy  in  1  transmitter streaming (high from cycle after accept until done/abort)
- rd_addr  in  ADDR_WIDTH  transmitter word address
- rd_data  out  16  ram_rdata of buffer buf_sel (combinational mux)
- ram_addr0 / ram_addr1  out  ADDR_WIDTH  SPRAM address per buffer
- ram_wdata0 / ram_wdata1  out  16  SPRAM write data (both = pix_data)
- ram_we0 / ram_we1  out  1  SPRAM write enable
- ram_rdata0 / ram_rdata1  in  16  SPRAM read data (1-cycle registered read)
- frames_dropped  out  8  saturating count of dropped/truncated frames

## Operation
- Per-buffer state b[i] ∈ {FREE, FILLING, FULL, SENDING}.
- Writer FSM: W_WAIT_SOF, W_FILL, W_DROP.
  - W_WAIT_SOF/W_DROP + cam_sof: pick a FREE buffer (both FREE: the buffer not last filled; after reset, 0). Set it FILLING, wr_addr=0, go W_FILL. No FREE buffer: go W_DROP, frames_dropped+1.
  - W_FILL + pix_valid: ram_we of the fill buffer = 1, addr = wr_addr, wr_addr+1. The write at wr_addr == FRAME_WORDS-1 sets the buffer FULL and goes W_WAIT_SOF.
  - W_FILL + cam_sof (truncated frame): frames_dropped+1. Restart the same buffer at wr_addr=0 and stay in W_FILL. The write of a coincident pix_valid goes to address 0 of the new frame.
  - pix_valid outside W_FILL is ignored. Writes never occur to FULL or SENDING buffers.
- Reader FSM: R_IDLE, R_OFFER, R_WAIT_BUSY, R_SEND.
  - R_IDLE with a FULL buffer: set buf_sel to it (oldest FULL first) and go R_OFFER.
  - R_OFFER: frame_ready=1 for exactly this cycle, buffer -> SENDING, go R_WAIT_BUSY.
  - R_WAIT_BUSY: frame_busy high -> R_SEND.
  - R_SEND: frame_busy low (completion or CS abort) -> buffer FREE, R_IDLE. An aborted frame is not re-offered.
  - buf_sel only changes in R_IDLE.
- SPRAM port mux per buffer:
  - FILLING: addr = wr_addr, we = W_FILL & pix_valid.
  - SENDING: addr = rd_addr, we = 0.
  - Otherwise: addr = 0, we = 0.
- frames_dropped saturates at 255 and never wraps.

## Timing
- Reset values:
  - Outputs: frame_ready=0, buf_sel=0, ram_we0/1=0, ram_addr0/1=0, frames_dropped=0.
  - Internal: both buffers FREE, W_WAIT_SOF, R_IDLE, last-filled=1.
- Reset mid-frame or mid-send discards all buffer contents and state immediately. No frame_ready is issued for partial data.
- Pixel write latency: the SPRAM write occurs in the cycle pix_valid is sampled (addr/we combinational from registered state).
- Last write at cycle N -> buffer FULL at N+1 -> frame_ready pulse at N+2 when the reader is idle.
- rd_data follows buf_sel combinationally. The 1-cycle SPRAM read latency relative to rd_addr is the transmitter's concern.
- Simultaneous events:
  - Decisions use registered buffer states. A buffer freed in cycle N is not eligible for a cam_sof in cycle N; that frame drops.
  - A FULL and a FREE/SEND transition in the same cycle both take effect.
- Ordering: frames are delivered in capture order. At most one buffer is SENDING at any time.

## Test plan
- FRAME_WORDS=16; SOF + 16 pixels 0x0000..0x000F:
  - ram_we0 asserted on 16 cycles, addr 0..15.
  - frame_ready one cycle with buf_sel=0.
  - rd_addr=5 while SENDING -> ram_addr0=5.
- Transmitter busy on buffer 0; second frame fills buffer 1 and goes FULL.
  - Third SOF -> W_DROP, frames_dropped=1, no writes.
  - frame_busy falls -> buffer 0 FREE, then frame_ready with buf_sel=1.
- SOF after 7 of 16 pixels -> frames_dropped+1, same buffer restarts at addr 0, full frame completes normally.
- frame_busy high 100 cycles then low (CS abort) -> buffer freed, no re-offer, next full frame offered normally.
- Assert rst_n=0 mid-fill and mid-send -> all outputs at reset values next cycle; first subsequent frame uses buffer 0.
- 300 consecutive frames with the transmitter stalled -> frames_dropped saturates at 255.
